// File: rtl/time_keeper.sv
// time_keeper: BCD hh:mm:ss clock with set mode and alarm pulse.
// Define TWELVE_HOUR_EN for 12-hour counting with a PM flag (default build is 24-hour).
module time_keeper (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sec_inc,
  input  logic       set_mode,
  input  logic       hr_btn,
  input  logic       min_btn,
  input  logic       alarm_en,
  input  logic [7:0] alarm_hr,
  input  logic [7:0] alarm_min,
  input  logic       alarm_pm,
  output logic [7:0] hr,
  output logic [7:0] min,
  output logic [7:0] sec,
  output logic       pm,
  output logic       min_tick,
  output logic       day_wrap,
  output logic       alarm_match
);
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    return (v == top) ? 8'h00 : (v[3:0] == 4'h9) ? {v[7:4] + 4'h1, 4'h0} : v + 8'h01;
  endfunction
`ifdef TWELVE_HOUR_EN
  localparam logic [7:0] HR_RST = 8'h12;
  wire [7:0] hr_step = (hr == 8'h12) ? 8'h01 : (hr == 8'h11) ? 8'h12 : bcd_inc(hr, 8'hff);
  wire       hr_flip = hr == 8'h11;
  wire       hr_last = hr == 8'h11 && pm;
`else
  localparam logic [7:0] HR_RST = 8'h00;
  wire [7:0] hr_step = bcd_inc(hr, 8'h23);
  wire       hr_flip = 1'b0;
  wire       hr_last = hr == 8'h23;
  logic unused_pm;
  assign unused_pm = alarm_pm;
`endif
  logic [7:0] hr_n, min_n, sec_n;
  logic       pm_n, tick_n, wrap_n, match_n;
  always_comb begin
    hr_n    = hr;
    min_n   = min;
    sec_n   = sec;
    pm_n    = pm;
    tick_n  = 1'b0;
    wrap_n  = 1'b0;
    match_n = 1'b0;
    if (set_mode) begin
      sec_n = 8'h00;
      if (hr_btn) begin
        hr_n = hr_step;
        pm_n = pm ^ hr_flip;
      end
      if (min_btn) min_n = bcd_inc(min, 8'h59);
    end else if (sec_inc) begin
      sec_n  = bcd_inc(sec, 8'h59);
      tick_n = sec == 8'h59;
      if (tick_n) begin
        min_n = bcd_inc(min, 8'h59);
        if (min == 8'h59) begin
          hr_n   = hr_step;
          pm_n   = pm ^ hr_flip;
          wrap_n = hr_last;
        end
      end
      // sec rolls to 00 only with tick_n, so the alarm can only hit on a minute boundary
      match_n = alarm_en && tick_n && hr_n == alarm_hr && min_n == alarm_min;
`ifdef TWELVE_HOUR_EN
      match_n = match_n && pm_n == alarm_pm;
`endif
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      hr          <= HR_RST;
      min         <= 8'h00;
      sec         <= 8'h00;
      pm          <= 1'b0;
      min_tick    <= 1'b0;
      day_wrap    <= 1'b0;
      alarm_match <= 1'b0;
    end else begin
      hr          <= hr_n;
      min         <= min_n;
      sec         <= sec_n;
      pm          <= pm_n;
      min_tick    <= tick_n;
      day_wrap    <= wrap_n;
      alarm_match <= match_n;
    end
endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  in  1  system clock, 48 MHz; all state on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 sec_inc  in  1  one-cycle pulse, once per second, from the upstream second counter.
REQ-005 set_mode  in  1  level; 1 = manual time-set mode, 0 = run.
REQ-006 hr_btn  in  1  one-cycle pulse; hour +1 while set_mode=1.
REQ-007 min_btn  in  1  one-cycle pulse; minute +1 while set_mode=1.
REQ-008 alarm_en  in  1  level; enables alarm compare.
REQ-009 alarm_hr  in  8  packed BCD hour {tens,ones}.
REQ-010 alarm_min  in  8  packed BCD minute {tens,ones}.
REQ-011 alarm_pm  in  1  alarm PM flag; used only with TWELVE_HOUR_EN.
REQ-012 hr, min, sec  out  8 each  packed BCD current time, registered.
REQ-013 pm  out  1  PM flag, registered.
REQ-014 min_tick  out  1  one-cycle pulse on run-mode seconds wrap 59->00.
REQ-015 day_wrap  out  1  one-cycle pulse on run-mode midnight rollover.
REQ-016 alarm_match  out  1  one-cycle pulse on alarm hit.

Function
REQ-017 All outputs are registered; effect of any input pulse is visible exactly 1 cycle later.
REQ-018 Run mode (set_mode=0), sec_inc=1: sec +1 in BCD; ones 9->0 carries to tens; sec 59->00 pulses min_tick and carries into min.
REQ-019 min 59->00 on carry carries into hr; no other minute/hour change occurs in run mode.
REQ-020 24-hour hr sequence 00..23; 23:59:59 + sec_inc -> 00:00:00 with day_wrap=1 same cycle as the update.
REQ-021 Set mode: sec_inc ignored; sec forced to 00 on the first cycle of set_mode=1 and held there.
REQ-022 Set mode: hr_btn advances hr one step, wrapping without day_wrap; min_btn advances min 59->00 without carry into hr.
REQ-023 hr_btn and min_btn in the same cycle: both applied independently.
REQ-024 sec_inc coincident with set_mode=1: set mode wins; sec_inc dropped.
REQ-025 hr_btn/min_btn while set_mode=0: ignored.
REQ-026 set_mode 1->0: counting resumes from 00 seconds on the next sec_inc; no pulse generated.
REQ-027 alarm_match=1 for one cycle when a run-mode sec_inc update produces hr==alarm_hr, min==alarm_min, sec==00 (and pm==alarm_pm if TWELVE_HOUR_EN), with alarm_en=1.
REQ-028 Time reached by set-mode edits never asserts alarm_match.
REQ-029 Non-BCD or out-of-range alarm values (e.g. hr 8'h25, min 8'h6A) never match; no error output.
REQ-030 min_tick, day_wrap, alarm_match never assert for more than one consecutive cycle.

Reset
REQ-031 reset_n=0 immediately clears all state regardless of clk: hr=00 (24h) or 12 (12h), min=00, sec=00, pm=0, all pulse outputs 0.
REQ-032 Reset asserted mid-carry or mid-set discards the operation; first sec_inc after release yields 00:00:01 (24h) / 12:00:01 AM (12h).

Configuration
REQ-033 Macro TWELVE_HOUR_EN defined: hr sequence 12,01..11; 11->12 toggles pm in both run and set mode; day_wrap when 11:59:59 PM -> 12:00:00 AM; alarm compare includes alarm_pm.
REQ-034 TWELVE_HOUR_EN undefined: 24-hour behaviour per REQ-020; pm tied 0; alarm_pm ignored.

Verification
REQ-035 Reset, then 61 sec_inc pulses -> 00:01:01, min_tick pulsed once at the 60th pulse.
REQ-036 Set to 23:59 via buttons, leave set mode, 60 sec_inc -> 00:00:00, day_wrap one cycle.
REQ-037 alarm_en=1, alarm 07:30, start 07:29:00, 60 sec_inc -> alarm_match one cycle with 07:30:00; repeat alarm_en=0 -> no pulse.
REQ-038 set_mode=1 with sec_inc, hr_btn, min_btn in same cycle at 10:59:30 -> 11:00:00, no min_tick, no carry.
REQ-039 reset_n low for half a cycle during 00:00:59 carry -> all outputs 00:00:00 asynchronously, pulses 0.
REQ-040 TWELVE_HOUR_EN: 11:59:59 AM + sec_inc -> 12:00:00, pm=1; 11:59:59 PM + sec_inc -> 12:00:00, pm=0, day_wrap=1.
